// File: rtl/sdram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the two-requester SDRAM arbiter.
//   SDRAM_ADDR_W  : width of SDRAM command / return addresses
//   ID_DCACHE     : requester id of the data cache
//   ID_ICACHE     : requester id of the instruction cache
//   sdram_cmd_t   : one requester's command fields, bundled so the grant mux
//                   selects a whole command at once
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int   SDRAM_ADDR_W = 26;
    localparam logic ID_DCACHE    = 1'b0;
    localparam logic ID_ICACHE    = 1'b1;

    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] addr;
        logic                    write;
        logic                    burst;
        logic [3:0]              wstrb;
        logic [31:0]             wdata;
    } sdram_cmd_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_if
// Bundles every bus signal around the arbiter: the dcache and icache command
// ports, their read-return ports, and the command / return port of the SDRAM
// controller.
//   modport slave  : the arbiter's view (takes requester commands and
//                    controller returns, drives readies, rvalids, muxed command)
//   modport master : the environment's view (requesters plus controller)
// -----------------------------------------------------------------------------
interface sdram_arbiter_if;
    import sdram_arb_pkg::*;

    // dcache requester
    logic                    dcache_sdram_request;
    logic                    dcache_sdram_ready;
    logic [SDRAM_ADDR_W-1:0] dcache_sdram_addr;
    logic                    dcache_sdram_write;
    logic                    dcache_sdram_burst;
    logic [3:0]              dcache_sdram_wstrb;
    logic [31:0]             dcache_sdram_wdata;
    logic                    dcache_sdram_rvalid;
    logic [31:0]             dcache_sdram_rdata;
    logic [SDRAM_ADDR_W-1:0] dcache_sdram_raddress;
    logic                    dcache_sdram_complete;

    // icache requester
    logic                    icache_sdram_request;
    logic                    icache_sdram_ready;
    logic [SDRAM_ADDR_W-1:0] icache_sdram_addr;
    logic                    icache_sdram_write;
    logic                    icache_sdram_burst;
    logic [3:0]              icache_sdram_wstrb;
    logic [31:0]             icache_sdram_wdata;
    logic                    icache_sdram_rvalid;
    logic [31:0]             icache_sdram_rdata;
    logic [SDRAM_ADDR_W-1:0] icache_sdram_raddress;
    logic                    icache_sdram_complete;

    // SDRAM controller
    logic                    sdram_ready;
    logic                    sdram_request;
    logic [SDRAM_ADDR_W-1:0] sdram_addr;
    logic                    sdram_write;
    logic                    sdram_burst;
    logic [3:0]              sdram_wstrb;
    logic [31:0]             sdram_wdata;
    logic                    sdram_rvalid;
    logic [31:0]             sdram_rdata;
    logic [SDRAM_ADDR_W-1:0] sdram_raddress;
    logic                    sdram_complete;

    logic                    arb_error;

    modport slave (
        input  dcache_sdram_request, dcache_sdram_addr, dcache_sdram_write,
               dcache_sdram_burst, dcache_sdram_wstrb, dcache_sdram_wdata,
        output dcache_sdram_ready, dcache_sdram_rvalid, dcache_sdram_rdata,
               dcache_sdram_raddress, dcache_sdram_complete,
        input  icache_sdram_request, icache_sdram_addr, icache_sdram_write,
               icache_sdram_burst, icache_sdram_wstrb, icache_sdram_wdata,
        output icache_sdram_ready, icache_sdram_rvalid, icache_sdram_rdata,
               icache_sdram_raddress, icache_sdram_complete,
        input  sdram_ready, sdram_rvalid, sdram_rdata, sdram_raddress, sdram_complete,
        output sdram_request, sdram_addr, sdram_write, sdram_burst, sdram_wstrb,
               sdram_wdata, arb_error
    );

    modport master (
        output dcache_sdram_request, dcache_sdram_addr, dcache_sdram_write,
               dcache_sdram_burst, dcache_sdram_wstrb, dcache_sdram_wdata,
        input  dcache_sdram_ready, dcache_sdram_rvalid, dcache_sdram_rdata,
               dcache_sdram_raddress, dcache_sdram_complete,
        output icache_sdram_request, icache_sdram_addr, icache_sdram_write,
               icache_sdram_burst, icache_sdram_wstrb, icache_sdram_wdata,
        input  icache_sdram_ready, icache_sdram_rvalid, icache_sdram_rdata,
               icache_sdram_raddress, icache_sdram_complete,
        output sdram_ready, sdram_rvalid, sdram_rdata, sdram_raddress, sdram_complete,
        input  sdram_request, sdram_addr, sdram_write, sdram_burst, sdram_wstrb,
               sdram_wdata, arb_error
    );

endinterface

// File: rtl/sdram_arbiter_owner_fifo.sv
// -----------------------------------------------------------------------------
// arb_owner_fifo
// In-order record of which requester owns each outstanding SDRAM read.
//   clock, reset : clock, asynchronous active-high reset
//   push, push_id: append a requester id (accepted read)
//   pop          : drop the head entry (final beat of the head read)
//   head_id      : owner of the oldest outstanding read
//   count        : number of outstanding reads, 0..DEPTH
//   empty        : count == 0
// Push and pop in the same cycle both take effect and leave count unchanged.
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module arb_owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         push_id,
    input  logic                         pop,
    output logic                         head_id,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    // NOTE: the storage array carries no reset; validity is defined solely by
    // the pointers and count, so resetting the entries would only cost logic.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_ONE;
            end else if (pop && !push) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    assign head_id = mem[rd_ptr];
    assign count   = cnt;
    assign empty   = (cnt == '0);

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Shares one SDRAM controller between a data cache and an instruction cache.
//   clock, reset : clock, asynchronous active-high reset
//   bus (slave)  : requester command ports (request/ready/addr/write/burst/
//                  wstrb/wdata), requester return ports (rvalid plus broadcast
//                  rdata/raddress/complete), controller command and return
//                  ports, and the sticky arb_error flag.
// Grant is combinational with a 1-bit round-robin pointer; an accepted read
// records its requester in an owner FIFO so that returning beats are steered
// to the right cache. A beat arriving with no outstanding owner is dropped
// and sets arb_error until reset.
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int OWNER_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    sdram_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(OWNER_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OWNER_DEPTH);

    sdram_cmd_t       dcache_cmd;
    sdram_cmd_t       icache_cmd;
    sdram_cmd_t       grant_cmd;
    logic [CNT_W-1:0] owner_count;
    logic             owner_empty;
    logic             owner_full;
    logic             head_id;
    logic             beat_owned;
    logic             pop;
    logic             push;
    logic             dcache_eligible;
    logic             icache_eligible;
    logic             grant_valid;
    logic             grant_id;
    logic             accept;
    logic             rr;
    logic             arb_error_q;

    assign dcache_cmd = '{bus.dcache_sdram_addr, bus.dcache_sdram_write, bus.dcache_sdram_burst,
                          bus.dcache_sdram_wstrb, bus.dcache_sdram_wdata};
    assign icache_cmd = '{bus.icache_sdram_addr, bus.icache_sdram_write, bus.icache_sdram_burst,
                          bus.icache_sdram_wstrb, bus.icache_sdram_wdata};

    // Return path: a beat is owned only while some read is outstanding; the
    // head entry retires on the beat flagged complete.
    assign owner_full = (owner_count == CNT_FULL);
    assign beat_owned = bus.sdram_rvalid & ~owner_empty;
    assign pop        = beat_owned & bus.sdram_complete;

    // A read is held off while every owner slot is taken, except in the cycle
    // whose final beat frees the head slot: the new owner then takes its place.
    assign dcache_eligible = bus.dcache_sdram_request &
                             (bus.dcache_sdram_write | ~owner_full | pop);
    assign icache_eligible = bus.icache_sdram_request &
                             (bus.icache_sdram_write | ~owner_full | pop);

    // NOTE: every variable written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        grant_id = ID_DCACHE;
        if (dcache_eligible && icache_eligible) begin
            grant_id = rr;
        end else if (icache_eligible) begin
            grant_id = ID_ICACHE;
        end
    end

    assign grant_valid = dcache_eligible | icache_eligible;
    // With no grant the dcache fields are presented, as grant_id defaults to it.
    assign grant_cmd   = (grant_id == ID_ICACHE) ? icache_cmd : dcache_cmd;
    assign accept      = grant_valid & bus.sdram_ready;
    assign push        = accept & ~grant_cmd.write;

    assign bus.sdram_request      = grant_valid;
    assign bus.sdram_addr         = grant_cmd.addr;
    assign bus.sdram_write        = grant_cmd.write;
    assign bus.sdram_burst        = grant_cmd.burst;
    assign bus.sdram_wstrb        = grant_cmd.wstrb;
    assign bus.sdram_wdata        = grant_cmd.wdata;
    assign bus.dcache_sdram_ready = accept & (grant_id == ID_DCACHE);
    assign bus.icache_sdram_ready = accept & (grant_id == ID_ICACHE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr          <= ID_DCACHE;
            arb_error_q <= 1'b0;
        end else begin
            if (accept) begin
                rr <= ~grant_id;
            end
            if (bus.sdram_rvalid && owner_empty) begin
                arb_error_q <= 1'b1;
            end
        end
    end

    arb_owner_fifo #(
        .DEPTH   (OWNER_DEPTH)
    ) u_owner_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .push_id (grant_id),
        .pop     (pop),
        .head_id (head_id),
        .count   (owner_count),
        .empty   (owner_empty)
    );

    assign bus.dcache_sdram_rvalid   = beat_owned & (head_id == ID_DCACHE);
    assign bus.icache_sdram_rvalid   = beat_owned & (head_id == ID_ICACHE);
    assign bus.dcache_sdram_rdata    = bus.sdram_rdata;
    assign bus.icache_sdram_rdata    = bus.sdram_rdata;
    assign bus.dcache_sdram_raddress = bus.sdram_raddress;
    assign bus.icache_sdram_raddress = bus.sdram_raddress;
    assign bus.dcache_sdram_complete = bus.sdram_complete;
    assign bus.icache_sdram_complete = bus.sdram_complete;
    assign bus.arb_error             = arb_error_q;

endmodule
